// File: rtl/boa_peri_timer_if.sv
// Data-side memory bus between the CPU mux and a peripheral slave.
interface boa_mem_bus;
  logic        re;
  logic [3:0]  we;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;

  modport MEM (input re, we, addr, wdata, output rdata, ready);
  modport CPU (output re, we, addr, wdata, input rdata, ready);
endinterface

// File: rtl/boa_peri_timer.sv
// 32-bit down-counting timer with prescaler, auto-reload and sticky expiry irq.
// Optional compare/PWM output enabled by defining BOA_PERI_TIMER_PWM_EN.
module boa_peri_timer #(
  parameter int unsigned pre_bits = 16
) (
  input  logic      clk,
  input  logic      rst,
  boa_mem_bus.MEM   bus,
  output logic      irq,
  output logic      pwm
);

  localparam int unsigned DW = 32;
  localparam logic [5:0] A_CTRL   = 6'h00;
  localparam logic [5:0] A_PRE    = 6'h01;
  localparam logic [5:0] A_RELOAD = 6'h02;
  localparam logic [5:0] A_COUNT  = 6'h03;
  localparam logic [5:0] A_STATUS = 6'h04;
  localparam logic [5:0] A_CMP    = 6'h05;

  logic                en;
  logic                auto_rl;
  logic                irq_en;
  logic [pre_bits-1:0] prescale;
  logic [pre_bits-1:0] pre_cnt;
  logic [DW-1:0]       reload;
  logic [DW-1:0]       count;
  logic                exp_flag;
  logic [DW-1:0]       rdata_q;
  logic [DW-1:0]       compare_rd;

  logic [5:0]          idx;
  logic                wr_any;
  logic                wr_ctrl;
  logic                wr_count;
  logic                tick;
  logic                expire;
  logic                status_clr;
  logic [DW-1:0]       rd_val;
  logic [1:0]          unused_addr;

  // Byte-lane merge of a write into an existing 32-bit value.
  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old,
                                          input logic [DW-1:0] wd,
                                          input logic [3:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    end
    return r;
  endfunction

  assign idx         = bus.addr[7:2];
  assign unused_addr = bus.addr[1:0];
  assign wr_any      = |bus.we;
  assign wr_ctrl     = bus.we[0] && (idx == A_CTRL);
  assign wr_count    = wr_any && (idx == A_COUNT);
  assign status_clr  = bus.we[0] && bus.wdata[0] && (idx == A_STATUS);
  assign tick        = en && (pre_cnt == '0);
  // A COUNT write in the same cycle swallows the tick entirely.
  assign expire      = tick && !wr_count && (count == '0);

  assign bus.ready = 1'b1;
  assign bus.rdata = rdata_q;

  always_comb begin
    rd_val = '0;
    case (idx)
      A_CTRL:   rd_val = {29'd0, irq_en, auto_rl, en};
      A_PRE:    rd_val = DW'(prescale);
      A_RELOAD: rd_val = reload;
      A_COUNT:  rd_val = count;
      A_STATUS: rd_val = {31'd0, exp_flag};
      A_CMP:    rd_val = compare_rd;
      default:  rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en       <= 1'b0;
      auto_rl  <= 1'b0;
      irq_en   <= 1'b0;
      prescale <= '0;
      pre_cnt  <= '0;
      reload   <= '0;
      count    <= '0;
      exp_flag <= 1'b0;
      rdata_q  <= '0;
      irq      <= 1'b0;
    end else begin
      if (bus.re) rdata_q <= rd_val;
      irq <= exp_flag & irq_en;

      if (en) pre_cnt <= (pre_cnt == '0) ? prescale : pre_cnt - pre_bits'(1);
      if (wr_ctrl && bus.wdata[0] && !en) pre_cnt <= prescale;

      if (tick && !wr_count) begin
        if (count != '0)  count <= count - DW'(1);
        else if (auto_rl) count <= reload;
        else              en    <= 1'b0;
      end

      // Expiry set has priority over a software clear.
      if (expire)          exp_flag <= 1'b1;
      else if (status_clr) exp_flag <= 1'b0;

      if (wr_ctrl) {irq_en, auto_rl, en} <= bus.wdata[2:0];
      if (wr_any && idx == A_PRE)
        prescale <= pre_bits'(merge(DW'(prescale), bus.wdata, bus.we));
      if (wr_any && idx == A_RELOAD) reload <= merge(reload, bus.wdata, bus.we);
      if (wr_count) count <= merge(count, bus.wdata, bus.we);
    end
  end

`ifdef BOA_PERI_TIMER_PWM_EN
  logic [DW-1:0] compare;
  logic          pwm_q;

  assign compare_rd = compare;
  assign pwm        = pwm_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      compare <= '0;
      pwm_q   <= 1'b0;
    end else begin
      pwm_q <= en && (count < compare);
      if (wr_any && idx == A_CMP) compare <= merge(compare, bus.wdata, bus.we);
    end
  end
`else
  assign compare_rd = '0;
  assign pwm        = 1'b0;
`endif

endmodule

// File: tb/tb_boa_peri_timer.sv
// Bench for boa_peri_timer: cycle model of the register rules plus directed checks.
module tb_boa_peri_timer;

`ifdef BOA_PERI_TIMER_PWM_EN
  localparam bit PWM_ON = 1'b1;
`else
  localparam bit PWM_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic irq;
  logic pwm;
  boa_mem_bus bus_i();

  boa_peri_timer #(.pre_bits(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_i),
    .irq (irq),
    .pwm (pwm)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit checking = 1'b0;

  // Model state
  bit          m_en, m_auto, m_ie, m_exp, m_irq, m_pwm;
  logic [31:0] m_pre, m_phase, m_reload, m_count, m_cmp, m_rdata;

  function automatic logic [31:0] lanes(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (old & ~mask) | (wd & mask);
  endfunction

  function automatic logic [31:0] model_read(input int off);
    case (off)
      0: return {29'd0, m_ie, m_auto, m_en};
      1: return m_pre;
      2: return m_reload;
      3: return m_count;
      4: return {31'd0, m_exp};
      5: return m_cmp;
      default: return 32'd0;
    endcase
  endfunction

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", nm, act, req, cyc);
    end
  endfunction

  // Register-level behaviour, evaluated once per rising edge from pre-edge values.
  always @(posedge clk) begin : model
    int          off;
    logic [3:0]  be;
    logic [31:0] wd;
    bit          fire, cnt_wr, was_en, expired;
    cyc++;
    if (rst) begin
      m_en = 0; m_auto = 0; m_ie = 0; m_exp = 0; m_irq = 0; m_pwm = 0;
      m_pre = 0; m_phase = 0; m_reload = 0; m_count = 0; m_cmp = 0; m_rdata = 0;
    end else begin
      off = int'(bus_i.addr[7:2]);
      be  = bus_i.we;
      wd  = bus_i.wdata;
      if (bus_i.re) m_rdata = model_read(off);
      m_irq   = m_exp && m_ie;
      m_pwm   = PWM_ON && m_en && (m_count < m_cmp);
      fire    = m_en && (m_phase == 0);
      cnt_wr  = (be != 0) && (off == 3);
      was_en  = m_en;
      expired = 0;
      if (m_en) m_phase = (m_phase == 0) ? m_pre : m_phase - 1;
      if (fire && !cnt_wr) begin
        if (m_count > 0) m_count = m_count - 1;
        else begin
          expired = 1;
          if (m_auto) m_count = m_reload;
          else m_en = 0;
        end
      end
      if (expired) m_exp = 1;
      else if (off == 4 && be[0] && wd[0]) m_exp = 0;
      if (off == 0 && be[0]) begin
        if (!was_en && wd[0]) m_phase = m_pre;
        m_en = wd[0]; m_auto = wd[1]; m_ie = wd[2];
      end
      if (off == 1) m_pre = lanes(m_pre, wd, be) & 32'h0000FFFF;
      if (off == 2) m_reload = lanes(m_reload, wd, be);
      if (off == 3) m_count = lanes(m_count, wd, be);
      if (off == 5 && PWM_ON) m_cmp = lanes(m_cmp, wd, be);
    end
  end

  // Continuous comparison of all outputs against the model.
  always @(negedge clk) begin
    if (checking) begin
      chk("irq_vs_model", 32'(irq), 32'(m_irq));
      chk("pwm_vs_model", 32'(pwm), 32'(m_pwm));
      chk("rdata_vs_model", bus_i.rdata, m_rdata);
    end
  end

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    bus_i.addr = a; bus_i.wdata = d; bus_i.we = be; bus_i.re = 1'b0;
    @(negedge clk);
    bus_i.we = 4'h0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] req, input string nm);
    bus_i.addr = a; bus_i.re = 1'b1; bus_i.we = 4'h0;
    @(negedge clk);
    bus_i.re = 1'b0;
    chk(nm, bus_i.rdata, req);
  endtask

  task automatic wait_irq(output int at);
    at = -1000;
    for (int i = 0; i < 100; i++) begin
      if (irq === 1'b1) begin
        at = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin : stim
    int w, at1, at2, highs;
    bus_i.re = 1'b0; bus_i.we = 4'h0; bus_i.addr = 8'h00; bus_i.wdata = 32'h0;
    repeat (2) @(negedge clk);
    checking = 1'b1;
    chk("reset_irq", 32'(irq), 32'd0);
    chk("reset_pwm", 32'(pwm), 32'd0);
    chk("ready", 32'(bus_i.ready), 32'd1);
    rst = 1'b0;
    for (int a = 0; a < 6; a++) rd(8'(a * 4), 32'd0, "reset_reg");

    // Auto-reload period: (4+1)*(3+1) = 20 cycles
    wr(8'h04, 32'd3, 4'hF);
    wr(8'h08, 32'd4, 4'hF);
    wr(8'h0C, 32'd4, 4'hF);
    wr(8'h00, 32'h7, 4'hF);
    w = cyc;
    wait_irq(at1);
    chk("first_irq_latency", 32'(at1 - w), 32'd21);
    wr(8'h10, 32'h1, 4'hF);
    @(negedge clk);
    chk("irq_drop_after_clear", 32'(irq), 32'd0);
    wait_irq(at2);
    chk("second_irq_latency", 32'(at2 - w), 32'd41);
    chk("auto_period", 32'(at2 - at1), 32'd20);
    wr(8'h00, 32'h0, 4'hF);
    wr(8'h10, 32'h1, 4'hF);

    // One-shot: expiry on the 3rd tick
    wr(8'h04, 32'd0, 4'hF);
    wr(8'h0C, 32'd2, 4'hF);
    wr(8'h00, 32'h5, 4'hF);
    w = cyc;
    wait_irq(at1);
    chk("oneshot_irq_latency", 32'(at1 - w), 32'd4);
    rd(8'h00, 32'h4, "oneshot_ctrl");
    rd(8'h0C, 32'h0, "oneshot_count");
    wr(8'h10, 32'h1, 4'hE);
    rd(8'h10, 32'h1, "status_clear_needs_lane0");
    wr(8'h10, 32'h0, 4'hF);
    rd(8'h10, 32'h1, "status_write0_noop");
    wr(8'h10, 32'h1, 4'h1);
    rd(8'h10, 32'h0, "status_cleared");

    // COUNT write wins over a coinciding tick
    wr(8'h0C, 32'd100, 4'hF);
    wr(8'h00, 32'h1, 4'hF);
    repeat (3) @(negedge clk);
    wr(8'h0C, 32'd10, 4'hF);
    rd(8'h0C, 32'd10, "count_write_wins");
    rd(8'h0C, 32'd9, "count_resumes");
    wr(8'h00, 32'h0, 4'hF);

    // CTRL clearing EN on the one-shot expiry cycle
    wr(8'h0C, 32'd0, 4'hF);
    wr(8'h00, 32'h1, 4'hF);
    wr(8'h00, 32'h0, 4'hF);
    rd(8'h10, 32'h1, "ctrl_clear_exp_set");
    rd(8'h00, 32'h0, "ctrl_clear_en0");
    wr(8'h10, 32'h1, 4'hF);

    // RELOAD=0 auto: expiry every tick, set beats clear
    wr(8'h08, 32'd0, 4'hF);
    wr(8'h00, 32'h3, 4'hF);
    wr(8'h10, 32'h1, 4'hF);
    rd(8'h10, 32'h1, "set_beats_clear");
    wr(8'h00, 32'h0, 4'hF);
    wr(8'h10, 32'h1, 4'hF);
    rd(8'h10, 32'h0, "clear_when_idle");

    // Byte lanes, masking, unmapped and read-during-write
    wr(8'h08, 32'h11223344, 4'hF);
    wr(8'h08, 32'h0000AB00, 4'b0010);
    rd(8'h08, 32'h1122AB44, "byte_lane_reload");
    wr(8'h3C, 32'hDEADBEEF, 4'hF);
    rd(8'h3C, 32'h0, "unmapped_read");
    wr(8'h04, 32'hFFFFFFFF, 4'hF);
    rd(8'h04, 32'h0000FFFF, "prescale_mask");
    wr(8'h00, 32'hFFFFFFF8, 4'hF);
    rd(8'h00, 32'h0, "ctrl_upper_bits");
    bus_i.addr = 8'h08; bus_i.wdata = 32'h55; bus_i.we = 4'hF; bus_i.re = 1'b1;
    @(negedge clk);
    bus_i.we = 4'h0; bus_i.re = 1'b0;
    chk("read_during_write", bus_i.rdata, 32'h1122AB44);
    rd(8'h08, 32'h55, "after_rw");
    wr(8'h14, 32'h7, 4'hF);
    rd(8'h14, PWM_ON ? 32'h7 : 32'h0, "compare_reg");

    // Free-running PWM, then reset mid-count
    wr(8'h04, 32'd0, 4'hF);
    wr(8'h08, 32'd9, 4'hF);
    wr(8'h14, 32'd5, 4'hF);
    wr(8'h0C, 32'd9, 4'hF);
    wr(8'h00, 32'h7, 4'hF);
    repeat (12) @(negedge clk);
    highs = 0;
    for (int i = 0; i < 40; i++) begin
      if (pwm === 1'b1) highs++;
      @(negedge clk);
    end
    chk("pwm_duty", 32'(highs), PWM_ON ? 32'd20 : 32'd0);
    chk("irq_before_reset", 32'(irq), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("reset_mid_irq", 32'(irq), 32'd0);
    chk("reset_mid_pwm", 32'(pwm), 32'd0);
    rst = 1'b0;
    rd(8'h0C, 32'h0, "reset_mid_count");
    rd(8'h00, 32'h0, "reset_mid_ctrl");
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/boa_peri_timer.md
# boa_peri_timer

Memory-mapped 32-bit down-counting timer peripheral on the peripheral branch of the data-side memory mux, in an 8-bit address window next to the UART and PMU. It provides a programmable prescaler, one-shot or auto-reload operation and a sticky expiry flag. The flag drives one CPU external interrupt line (irq[18]).

## Interface
Parameters:
- `pre_bits`, default 16: prescaler width; PRESCALE register bits above `pre_bits` read 0 and ignore writes.

Ports:
- `clk` in 1: CPU clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `bus` boa_mem_bus.MEM: fields `re`, `we[3:0]` (byte enables), `addr`, `wdata[31:0]`, `rdata[31:0]`, `ready`; decode uses `addr[7:2]`.
- `irq` out 1: registered, level-sensitive interrupt request.
- `pwm` out 1: compare output; constant 0 unless `BOA_PERI_TIMER_PWM_EN` is defined.

## Operation
Register map (word offsets):
- 0x00 CTRL: [0] EN, [1] AUTO, [2] IRQ_EN; other bits read 0.
- 0x04 PRESCALE: [pre_bits-1:0].
- 0x08 RELOAD: 32-bit reload value.
- 0x0C COUNT: current counter, read/write.
- 0x10 STATUS: [0] EXP, sticky; writing 1 clears it, writing 0 has no effect.
- 0x14 COMPARE: present only with the PWM macro.
- Unmapped offsets read 0 and ignore writes.

Byte enables:
- Every write honours `we` byte lanes individually.
- A STATUS clear needs `we[0]` together with `wdata[0]`=1.

Prescaler and counter:
- Internal `pre_cnt` counts down while EN=1; a tick fires when `pre_cnt`==0, and `pre_cnt` then reloads to PRESCALE.
- A CTRL write that takes EN from 0 to 1 loads `pre_cnt` from PRESCALE.
- On a tick with COUNT≠0: COUNT decrements by 1.
- On a tick with COUNT==0: EXP is set. If AUTO=1, COUNT loads RELOAD. If AUTO=0, COUNT stays 0 and EN clears (one-shot).
- `irq` = registered (EXP & IRQ_EN).

Precedence when events coincide:
- Bus write to COUNT in the same cycle as a tick: the bus write wins and the tick is dropped.
- Bus write to CTRL clearing EN in the same cycle as a one-shot expiry: EN=0 and EXP is still set.
- STATUS clear in the same cycle as an expiry: the set wins, EXP stays 1.
- RELOAD=0 with AUTO=1: EXP is set on every tick.

Reset:
- All registers, `pre_cnt`, `rdata`, `irq` and `pwm` go to 0.
- Asserting `rst` mid-count abandons the count immediately and drops any pending bus read.

## Timing
- `ready` is constantly 1; there are no wait states.
- Read: `rdata` is registered and valid the cycle after `re`, holding its value until the next read.
- Write: the new value is visible to reads and to counter logic from the next cycle.
- Expiry period: (RELOAD+1)×(PRESCALE+1) cycles in auto-reload mode.
- Latency: `irq` rises 1 cycle after EXP is set, and falls 1 cycle after EXP or IRQ_EN clears.
- Simultaneous `re` and `we` to the same offset: `rdata` returns the pre-write value.

## Configuration
Macro: `BOA_PERI_TIMER_PWM_EN`.

Defined:
- COMPARE register exists at 0x14.
- `pwm` is registered, high when EN=1 and COUNT < COMPARE, updated every cycle.

Undefined:
- 0x14 reads 0 and ignores writes.
- `pwm` is tied to 0 and no compare logic is synthesised.
- The port list is identical either way.

## Test plan
- Reset, then read 0x00–0x14 → all return 0; `irq`=0, `pwm`=0.
- PRESCALE=3, RELOAD=4, COUNT=4, CTRL=0x7 → EXP set and `irq` high 20 cycles after the enable write, plus 1 cycle for `irq`; recurs every 20 cycles; STATUS write 1 drops `irq` 1 cycle later.
- One-shot: PRESCALE=0, COUNT=2, CTRL=0x5 → EXP after 3 ticks; CTRL reads 0x4; COUNT stays 0.
- Write COUNT=10 in the same cycle as a tick → COUNT reads 10, not 9; STATUS clear coinciding with expiry → EXP reads 1.
- Byte writes: `we`=4'b0010 with `wdata`=0x0000AB00 to RELOAD holding 0x11223344 → reads 0x1122AB44; read of 0x3C → 0.
- Macro defined, RELOAD=9, COMPARE=5, AUTO, PRESCALE=0 → `pwm` high for 5 of every 10 cycles; `rst` mid-run → `pwm`, `irq` and COUNT are 0 the next cycle.
